// File: rtl/array_dot_accum.sv
// Reduces n signed lane products per beat with a registered adder tree and
// accumulates the beat sums over a job into one saturated dot-product result.
module array_dot_accum #(
  parameter int n     = 4,
  parameter int DW    = 36,
  parameter int SUM_W = 48,
  parameter int LEN_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic              start,
  input  logic [LEN_W-1:0]  len,
  input  logic              in_valid,
  input  logic [n*DW-1:0]   products,
  output logic [SUM_W-1:0]  sum_out,
  output logic              done,
  output logic              busy,
  output logic              ovf
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] ACCUM = 2'd1;
  localparam logic [1:0] DRAIN = 2'd2;
  localparam logic [1:0] DONE  = 2'd3;

  logic [1:0]       r_state;
  logic [LEN_W-1:0] r_len_q;
  logic [LEN_W-1:0] r_count;
  logic [SUM_W-1:0] r_tree_q;
  logic             r_tree_v;
  logic [SUM_W-1:0] r_acc;
  logic             r_ovf;

  logic [SUM_W-1:0] w_tree;
  logic [SUM_W:0]   w_wide;
  logic             w_ovf;
  logic [SUM_W-1:0] w_sat;
  logic [SUM_W-1:0] w_acc_nxt;
  logic             w_accept;
  logic [LEN_W-1:0] w_cnt_nxt;
  logic             w_last;

  always_comb begin
    w_tree = '0;
    for (int i = 0; i < n; i++) begin
      w_tree = w_tree
        + {{(SUM_W-DW){products[i*DW+DW-1]}},
           products[i*DW +: DW]};
    end
  end

  // One extra bit catches overflow; the sign of the wide sum picks the rail.
  always_comb begin
    w_wide = {r_acc[SUM_W-1], r_acc}
           + {r_tree_q[SUM_W-1], r_tree_q};
    w_ovf  = w_wide[SUM_W] ^ w_wide[SUM_W-1];
    w_sat  = w_wide[SUM_W]
           ? {1'b1, {(SUM_W-1){1'b0}}}
           : {1'b0, {(SUM_W-1){1'b1}}};
    w_acc_nxt = w_ovf ? w_sat : w_wide[SUM_W-1:0];
  end

  assign w_accept  = (r_state == ACCUM) && in_valid;
  assign w_cnt_nxt = r_count + 1'b1;
  assign w_last    = w_accept && (w_cnt_nxt == r_len_q);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_tree_q <= '0;
      r_tree_v <= 1'b0;
    end else if (en) begin
      if (w_accept) r_tree_q <= w_tree;
      r_tree_v <= w_accept;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
      r_len_q <= '0;
      r_count <= '0;
      r_acc   <= '0;
      r_ovf   <= 1'b0;
    end else if (en) begin
      if (r_tree_v) begin
        r_acc <= w_acc_nxt;
        if (w_ovf) r_ovf <= 1'b1;
      end
      unique case (r_state)
        IDLE: begin
          if (start) begin
            r_acc <= '0;
            r_ovf <= 1'b0;
            if (len != '0) begin
              r_count <= '0;
              r_len_q <= len;
              r_state <= ACCUM;
            end else begin
              r_state <= DONE;
            end
          end
        end
        ACCUM: begin
          if (w_accept) begin
            r_count <= w_cnt_nxt;
            if (w_last) r_state <= DRAIN;
          end
        end
        DRAIN:   r_state <= DONE;
        DONE:    r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
    end
  end

  assign sum_out = r_acc;
  assign done    = (r_state == DONE);
  assign busy    = (r_state != IDLE);
  assign ovf     = r_ovf;

endmodule

// File: tb/tb_array_dot_accum.sv
// Directed bench for array_dot_accum: default build plus a SUM_W=40 build
// sharing the same stimulus to exercise saturation.
module tb_array_dot_accum;

  logic         clk = 1'b0;
  logic         rst;
  logic         en;
  logic         start;
  logic [7:0]   len;
  logic         in_valid;
  logic [143:0] products;

  logic [47:0]  sum48;
  logic         done48, busy48, ovf48;
  logic [39:0]  sum40;
  logic         done40, busy40, ovf40;

  int n_cmp  = 0;
  int n_bad  = 0;
  int n_done = 0;
  int cyc    = 0;
  int lat;
  int c0;
  int d0;

  array_dot_accum u_dut (
    .clk(clk), .rst(rst), .en(en), .start(start), .len(len),
    .in_valid(in_valid), .products(products),
    .sum_out(sum48), .done(done48), .busy(busy48), .ovf(ovf48)
  );

  array_dot_accum #(.SUM_W(40)) u_dut40 (
    .clk(clk), .rst(rst), .en(en), .start(start), .len(len),
    .in_valid(in_valid), .products(products),
    .sum_out(sum40), .done(done40), .busy(busy40), .ovf(ovf40)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (done48) n_done <= n_done + 1;
  end

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic put(input logic [35:0] a, input logic [35:0] b,
                     input logic [35:0] c, input logic [35:0] d);
    products = {d, c, b, a};
  endtask

  task automatic beat(input logic [35:0] a, input logic [35:0] b,
                      input logic [35:0] c, input logic [35:0] d);
    put(a, b, c, d);
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic idle(input int k);
    repeat (k) @(negedge clk);
  endtask

  task automatic go(input logic [7:0] l);
    start = 1'b1;
    len   = l;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done(output int n);
    n = 0;
    while (!done48 && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (!done48) n = -1;
  endtask

  localparam logic [35:0] M1  = 36'hF_FFFF_FFFF;
  localparam logic [35:0] BIG = 36'h7_FFFF_FFFF;

  initial begin
    rst = 1'b1; en = 1'b1; start = 1'b0; len = '0;
    in_valid = 1'b0; products = '0;
    #1;
    chk("rst_sum",  64'(sum48), 64'd0);
    chk("rst_done", 64'(done48), 64'd0);
    chk("rst_busy", 64'(busy48), 64'd0);
    chk("rst_ovf",  64'(ovf48), 64'd0);
    idle(2);
    rst = 1'b0;
    idle(1);

    // single beat
    go(1);
    chk("t2_busy", 64'(busy48), 64'd1);
    beat(1, 2, 3, 4);
    chk("t2_nodone", 64'(done48), 64'd0);
    idle(1);
    chk("t2_done", 64'(done48), 64'd1);
    chk("t2_sum",  64'(sum48), 64'd10);
    chk("t2_busy_d", 64'(busy48), 64'd1);
    idle(1);
    chk("t2_done_off", 64'(done48), 64'd0);
    chk("t2_busy_off", 64'(busy48), 64'd0);
    chk("t2_hold", 64'(sum48), 64'd10);

    // three beats with gaps
    c0 = cyc; d0 = n_done;
    go(3);
    beat(M1, M1, M1, M1);
    idle(1);
    beat(5, 5, 5, 5);
    idle(1);
    beat(0, 0, 0, 100);
    wait_done(lat);
    chk("t3_lat", 64'(lat), 64'd1);
    chk("t3_cyc", 64'(cyc - c0), 64'd7);
    chk("t3_sum", 64'(sum48), 64'd116);
    chk("t3_ovf", 64'(ovf48), 64'd0);
    idle(2);
    chk("t3_npulse", 64'(n_done - d0), 64'd1);

    // same job with a three-cycle stall after beat 2
    c0 = cyc;
    go(3);
    beat(M1, M1, M1, M1);
    idle(1);
    beat(5, 5, 5, 5);
    en = 1'b0;
    idle(2);
    chk("t5_stall_busy", 64'(busy48), 64'd1);
    chk("t5_stall_done", 64'(done48), 64'd0);
    idle(1);
    en = 1'b1;
    idle(1);
    beat(0, 0, 0, 100);
    wait_done(lat);
    chk("t5_cyc", 64'(cyc - c0), 64'd10);
    chk("t5_sum", 64'(sum48), 64'd116);
    idle(2);

    // zero-length job
    go(0);
    chk("len0_done", 64'(done48), 64'd1);
    chk("len0_sum",  64'(sum48), 64'd0);
    idle(1);
    chk("len0_off", 64'(done48), 64'd0);

    // saturation on the narrow build only
    go(5);
    repeat (5) beat(BIG, BIG, BIG, BIG);
    wait_done(lat);
    chk("t4_lat",   64'(lat), 64'd1);
    chk("t4_sum40", 64'(sum40), 64'h7F_FFFF_FFFF);
    chk("t4_ovf40", 64'(ovf40), 64'd1);
    chk("t4_sum48", 64'(sum48), 64'h9F_FFFF_FFEC);
    chk("t4_ovf48", 64'(ovf48), 64'd0);
    idle(1);
    chk("t4_sticky", 64'(ovf40), 64'd1);

    // start while busy is ignored; ovf clears on honoured start
    go(2);
    chk("t4_ovfclr", 64'(ovf40), 64'd0);
    start = 1'b1; len = 8'd7;
    beat(1, 1, 1, 1);
    start = 1'b0;
    beat(3, 3, 3, 3);
    wait_done(lat);
    chk("t6_lat", 64'(lat), 64'd1);
    chk("t6_sum", 64'(sum48), 64'd16);
    start = 1'b1; len = 8'd3;
    idle(1);
    start = 1'b0;
    chk("t6_donestart_busy", 64'(busy48), 64'd0);
    chk("t6_donestart_sum",  64'(sum48), 64'd16);

    // asynchronous reset mid-job
    go(3);
    beat(1, 1, 1, 1);
    idle(1);
    chk("t6_part_sum", 64'(sum48), 64'd4);
    chk("t6_part_busy", 64'(busy48), 64'd1);
    d0 = n_done;
    #2 rst = 1'b1;
    #1;
    chk("t1_async_sum",  64'(sum48), 64'd0);
    chk("t1_async_busy", 64'(busy48), 64'd0);
    chk("t1_async_done", 64'(done48), 64'd0);
    chk("t1_async_ovf",  64'(ovf48), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    idle(4);
    chk("t6_nodone", 64'(n_done - d0), 64'd0);
    chk("t6_idle_busy", 64'(busy48), 64'd0);

    // fresh job; beat coinciding with start is dropped
    start = 1'b1; len = 8'd1;
    put(9, 9, 9, 9);
    in_valid = 1'b1;
    @(negedge clk);
    start = 1'b0;
    in_valid = 1'b0;
    beat(2, 2, 2, 2);
    wait_done(lat);
    chk("t6_fresh_lat", 64'(lat), 64'd1);
    chk("t6_fresh_sum", 64'(sum48), 64'd8);
    idle(2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
